servo_bank: RTL and testbench

- Parametrised multi-channel servo PWM generator: CHANNELS independent pulse outputs share one frame timebase.
- Frame timebase = clock prescaler feeding a tick counter.
- Channel positions are double-buffered and applied only at frame boundaries, so no runt or stretched pulses occur.
- Sits between the control or register logic and the servo pins; replaces per-servo single-channel PWM instances.

---
 rtl/servo_bank.sv | 129 ++++++++++++
 tb/tb_servo_bank.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_bank.sv
`default_nettype none
// ============================================================================
// Module   : servo_bank
// Summary  : Multi-channel servo PWM with a shared frame timebase and
//            double-buffered positions applied at frame boundaries.
// Options  : SERVO_SLEW_EN - limit position change per frame to SLEW_STEP.
// Revision : 1.0
// ============================================================================
module servo_bank #(
    parameter int CHANNELS    = 4,
    parameter int VAL_WIDTH   = 8,
    parameter int TICK_DIV    = 195,
    parameter int MIN_TICKS   = 256,
    parameter int FRAME_TICKS = 5120,
    parameter int SLEW_STEP   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS*VAL_WIDTH-1:0] val,
    input  logic                          load,
    input  logic [CHANNELS-1:0]           ch_en,
    output logic                          busy,
    output logic                          frame_start,
    output logic [CHANNELS-1:0]           servo
);

    localparam int c_PS_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_TC_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int c_CMP_W = ((c_TC_W > VAL_WIDTH) ? c_TC_W : VAL_WIDTH) + 2;

    localparam logic [c_PS_W-1:0]    c_PS_LAST = c_PS_W'(TICK_DIV - 1);
    localparam logic [c_TC_W-1:0]    c_TC_LAST = c_TC_W'(FRAME_TICKS - 1);
    localparam logic [c_CMP_W-1:0]   c_MIN     = c_CMP_W'(MIN_TICKS);
    localparam logic [VAL_WIDTH-1:0] c_CENTRE  = VAL_WIDTH'(2 ** (VAL_WIDTH - 1));

    generate
        if (TICK_DIV < 1 || SLEW_STEP < 1 ||
            MIN_TICKS + 2 ** VAL_WIDTH - 1 >= FRAME_TICKS) begin : g_bad_params
            $error("servo_bank: illegal parameter combination");
        end
    endgenerate

    logic [c_PS_W-1:0]    r_prescale;
    logic [c_TC_W-1:0]    r_tick_ctr;
    logic [VAL_WIDTH-1:0] r_active  [CHANNELS];
    logic [VAL_WIDTH-1:0] r_pending [CHANNELS];
    logic [VAL_WIDTH-1:0] w_next_active [CHANNELS];
    logic [CHANNELS-1:0]  r_en_q;
    logic [CHANNELS-1:0]  r_servo;
    logic                 r_flag;
    logic                 r_frame_start;
    logic                 w_tick;
    logic                 w_boundary;
    logic                 w_all_settled;

    assign w_tick     = (r_prescale == c_PS_LAST);
    assign w_boundary = w_tick && (r_tick_ctr == c_TC_LAST);

`ifdef SERVO_SLEW_EN
    localparam logic [VAL_WIDTH-1:0] c_STEP = VAL_WIDTH'(SLEW_STEP);
`endif

    // Position each channel will take at the next boundary.
    always_comb begin
        w_all_settled = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            w_next_active[i] = r_pending[i];
`ifdef SERVO_SLEW_EN
            if (r_pending[i] > r_active[i]) begin
                if (int'(r_pending[i] - r_active[i]) > SLEW_STEP)
                    w_next_active[i] = r_active[i] + c_STEP;
            end else if (r_pending[i] < r_active[i]) begin
                if (int'(r_active[i] - r_pending[i]) > SLEW_STEP)
                    w_next_active[i] = r_active[i] - c_STEP;
            end
`endif
            if (w_next_active[i] != r_pending[i])
                w_all_settled = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescale <= '0;
            r_tick_ctr <= '0;
        end else if (w_tick) begin
            r_prescale <= '0;
            r_tick_ctr <= w_boundary ? '0 : r_tick_ctr + 1'b1;
        end else begin
            r_prescale <= r_prescale + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_active[i]  <= c_CENTRE;
                r_pending[i] <= c_CENTRE;
            end
            r_en_q        <= '0;
            r_servo       <= '0;
            r_flag        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_boundary;
            for (int i = 0; i < CHANNELS; i++) begin
                r_servo[i] <= r_en_q[i] &&
                              (c_CMP_W'(r_tick_ctr) < c_MIN + c_CMP_W'(r_active[i]));
                if (w_boundary)
                    r_active[i] <= w_next_active[i];
                if (load)
                    r_pending[i] <= val[i*VAL_WIDTH +: VAL_WIDTH];
            end
            if (w_boundary)
                r_en_q <= ch_en;
            // A load in the boundary cycle wins over the clear.
            if (load)
                r_flag <= 1'b1;
            else if (w_boundary && w_all_settled)
                r_flag <= 1'b0;
        end
    end

    assign busy        = r_flag;
    assign frame_start = r_frame_start;
    assign servo       = r_servo;

endmodule
`default_nettype wire

// File: tb/tb_servo_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_servo_bank
// Summary  : Randomised self-checking bench for servo_bank against a
//            frame-level reference model.
// Revision : 1.0
// ============================================================================
module tb_servo_bank;

    localparam int CH    = 2;
    localparam int VW    = 4;
    localparam int TD    = 2;
    localparam int MT    = 4;
    localparam int FT    = 40;
    localparam int SS    = 3;
    localparam int FRAME = FT * TD;

    logic            clk   = 1'b0;
    logic            rst   = 1'b1;
    logic            load  = 1'b0;
    logic [CH*VW-1:0] val  = '0;
    logic [CH-1:0]   ch_en = '0;
    logic            busy;
    logic            frame_start;
    logic [CH-1:0]   servo;

    servo_bank #(
        .CHANNELS(CH), .VAL_WIDTH(VW), .TICK_DIV(TD),
        .MIN_TICKS(MT), .FRAME_TICKS(FT), .SLEW_STEP(SS)
    ) dut (
        .clk(clk), .rst(rst), .val(val), .load(load), .ch_en(ch_en),
        .busy(busy), .frame_start(frame_start), .servo(servo)
    );

    always #5 clk = ~clk;

    // Reference model: k = clock edges since reset; frame position = (k-1) mod FRAME.
    int            k;
    int            m_act  [CH];
    int            m_pend [CH];
    logic [CH-1:0] m_en;
    logic          m_flag;
    logic [CH-1:0] exp_servo = '0;
    logic          exp_busy  = 1'b0;
    logic          exp_fs    = 1'b0;
    int            n_vec     = 0;
    int            n_bad     = 0;

    always @(posedge clk) begin
        if (rst) begin
            k = 0;
            for (int i = 0; i < CH; i++) begin
                m_act[i]  = 2 ** (VW - 1);
                m_pend[i] = 2 ** (VW - 1);
            end
            m_en = '0; m_flag = 1'b0;
            exp_servo = '0; exp_busy = 1'b0; exp_fs = 1'b0;
        end else begin
            k++;
            for (int i = 0; i < CH; i++)
                exp_servo[i] = m_en[i] && (((k - 1) % FRAME) < (MT + m_act[i]) * TD);
            exp_fs = (k % FRAME == 0);
            if (exp_fs) begin
                bit settled = 1'b1;
                for (int i = 0; i < CH; i++) begin
`ifdef SERVO_SLEW_EN
                    if (m_pend[i] > m_act[i])
                        m_act[i] += (m_pend[i] - m_act[i] < SS) ? m_pend[i] - m_act[i] : SS;
                    else
                        m_act[i] -= (m_act[i] - m_pend[i] < SS) ? m_act[i] - m_pend[i] : SS;
`else
                    m_act[i] = m_pend[i];
`endif
                    if (m_act[i] != m_pend[i]) settled = 1'b0;
                end
                m_en = ch_en;
                if (settled) m_flag = 1'b0;
            end
            if (load) begin
                for (int i = 0; i < CH; i++) m_pend[i] = int'(val[i*VW +: VW]);
                m_flag = 1'b1;
            end
            exp_busy = m_flag;
        end
    end

    task automatic test_reset();
        int n;
        rst = 1'b1; ch_en = '0; load = 1'b0; val = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({frame_start, busy, servo} !== '0) begin
            n_bad++;
            $display("FAIL reset_state got %b want 0", {frame_start, busy, servo});
        end
        ch_en = 2'b11; rst = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk); n++; n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL reset_frame k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            if (frame_start === 1'b1) break;
        end
        n_vec++;
        if (n != FRAME) begin
            n_bad++;
            $display("FAIL first_frame_start got %0d clk want %0d", n, FRAME);
        end
    endtask

    task automatic test_centre();
        int c0 = 0, c1 = 0;
        for (int n = 0; n < FRAME; n++) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL centre k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            c0 += int'(servo[0]); c1 += int'(servo[1]);
        end
        n_vec++;
        if (c0 != 24 || c1 != 24) begin
            n_bad++;
            $display("FAIL centre_width got %0d/%0d want 24/24", c0, c1);
        end
    endtask

    task automatic test_midframe_load();
        int c0 = 0, c1 = 0;
        while (k % FRAME != 30) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL mid_load_pre k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
        end
        val = {4'd15, 4'd0}; load = 1'b1;
        do begin
            @(negedge clk); load = 1'b0; n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL mid_load k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
        end while (k % FRAME != 0);
        for (int n = 0; n < FRAME; n++) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL mid_load_post k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            c0 += int'(servo[0]); c1 += int'(servo[1]);
        end
`ifndef SERVO_SLEW_EN
        n_vec++;
        if (c0 != 8 || c1 != 38) begin
            n_bad++;
            $display("FAIL mid_load_width got %0d/%0d want 8/38", c0, c1);
        end
`endif
    endtask

    task automatic test_boundary_load();
        int c [2];
        while (k % FRAME != FRAME - 1) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL bnd_load_pre k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
        end
        val = {4'd15, 4'd3}; load = 1'b1;
        @(negedge clk); load = 1'b0;
        for (int f = 0; f < 2; f++) begin
            c[f] = 0;
            for (int n = 0; n < FRAME; n++) begin
                @(negedge clk); n_vec++;
                if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                    n_bad++;
                    $display("FAIL bnd_load k=%0d got %b want %b", k,
                             {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
                end
                c[f] += int'(servo[0]);
            end
        end
`ifndef SERVO_SLEW_EN
        n_vec++;
        if (c[0] != 8 || c[1] != 14) begin
            n_bad++;
            $display("FAIL bnd_load_width got %0d,%0d want 8,14", c[0], c[1]);
        end
`endif
    endtask

    task automatic test_en_mid_pulse();
        int tail = 0, c0 = 0, c1 = 0;
        while (k % FRAME != 20) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL en_pre k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
        end
        ch_en = 2'b01;
        do begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL en_tail k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            tail += int'(servo[1]);
        end while (k % FRAME != 0);
        for (int n = 0; n < FRAME; n++) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL en_post k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            c0 += int'(servo[0]); c1 += int'(servo[1]);
        end
`ifndef SERVO_SLEW_EN
        n_vec++;
        if (tail != 18 || c0 != 14 || c1 != 0) begin
            n_bad++;
            $display("FAIL en_width got tail=%0d ch0=%0d ch1=%0d want 18/14/0", tail, c0, c1);
        end
`endif
    endtask

    task automatic test_rst_mid_pulse();
        int n = 0, c0 = 0, c1 = 0;
        while (k % FRAME != 5) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL rst_pre k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
        end
        val = {4'd1, 4'd1}; load = 1'b1;
        @(negedge clk); load = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; n_vec++;
        if ({frame_start, busy, servo} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid got %b want 0", {frame_start, busy, servo});
        end
        while (n < 200) begin
            @(negedge clk); n++; n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL rst_frame k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            c1 += int'(servo != '0);
            if (frame_start === 1'b1) break;
        end
        for (int m = 0; m < FRAME; m++) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL rst_post k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            c0 += int'(servo[0]);
        end
        n_vec++;
        if (n != FRAME || c1 != 0 || c0 != 24) begin
            n_bad++;
            $display("FAIL rst_timing got fs_at=%0d high_in_first=%0d ch0=%0d want %0d/0/24",
                     n, c1, c0, FRAME);
        end
    endtask

    task automatic test_random();
        ch_en = CH'($urandom);
        for (int n = 0; n < 12 * FRAME; n++) begin
            @(negedge clk); n_vec++;
            if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                n_bad++;
                $display("FAIL random k=%0d got %b want %b", k,
                         {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
            end
            load = ($urandom_range(0, 24) == 0);
            if (load) val = (CH*VW)'($urandom);
            if ($urandom_range(0, 59) == 0) ch_en = CH'($urandom);
            rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0; load = 1'b0;
    endtask

`ifdef SERVO_SLEW_EN
    task automatic test_slew();
        int w [4];
        int want [4] = '{24, 30, 36, 38};
        rst = 1'b1; ch_en = 2'b11; load = 1'b0;
        @(negedge clk); rst = 1'b0;
        while (k % FRAME != 0 || k == 0) @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            w[f] = 0;
            for (int n = 0; n < FRAME; n++) begin
                @(negedge clk); n_vec++;
                if ({frame_start, busy, servo} !== {exp_fs, exp_busy, exp_servo}) begin
                    n_bad++;
                    $display("FAIL slew k=%0d got %b want %b", k,
                             {frame_start, busy, servo}, {exp_fs, exp_busy, exp_servo});
                end
                load = (f == 0 && n == 10);
                if (load) val = {4'd15, 4'd15};
                w[f] += int'(servo[0]);
            end
            n_vec++;
            if (w[f] != want[f]) begin
                n_bad++;
                $display("FAIL slew_width frame %0d got %0d want %0d", f, w[f], want[f]);
            end
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL slew_busy got %b want 0", busy);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_centre();
        test_midframe_load();
        test_boundary_load();
        test_en_mid_pulse();
        test_rst_mid_pulse();
        test_random();
`ifdef SERVO_SLEW_EN
        test_slew();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
